pipe_stage_buf: RTL and testbench
=================================

# pipe_stage_buf

Parametrised pipeline stage register with a valid/ready handshake, synchronous flush and an optional two-entry skid buffer. It is the generic successor to the fixed-width stall/flush stage registers between IF/ID, ID/EX, EX/MEM and MEM/WB. Each stage boundary carries an arbitrary packed payload (PC, PC+4, instruction, control bits) as one `WIDTH`-bit word. Stall is expressed through backpressure rather than a dedicated stall pin.

## Interface
- `WIDTH`, 96: payload width in bits, ≥1.
- `NOP_VALUE`, `'0`: `WIDTH`-bit value driven on `out_data` whenever `out_valid`=0. Example: the instruction field set to 32'h00000013.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `flush`  in  1  kill all held entries this cycle.
- `in_valid`  in  1  upstream beat present.
- `in_ready`  out  1  stage can accept a beat.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  downstream beat present.
- `out_ready`  in  1  downstream accepts. Drive 0 to stall.
- `out_data`  out  WIDTH  downstream payload.
- `occupancy`  out  2  number of held entries: 0, 1 or 2.

## Operation
- Transfer in occurs when `in_valid`&&`in_ready`. Transfer out occurs when `out_valid`&&`out_ready`.
- Storage consists of a main entry M (drives `out_*`) and a skid entry S (macro-dependent).
- Invariant: S valid implies M valid. Beats leave strictly in arrival order.
- Output holds while stalled:
  - With `out_valid`=1 and `out_ready`=0, `out_data` and `out_valid` stay stable.
  - They stay stable until the beat is accepted or flushed.
- Whenever `out_valid`=0, `out_data`=`NOP_VALUE`.
- Priority is reset > flush > normal operation.
- Flush behaviour:
  - Invalidates M and S at the clock edge.
  - Any beat handshaken in the flush cycle is discarded.
  - Next cycle: `out_valid`=0, `out_data`=`NOP_VALUE`, `occupancy`=0.
- Normal update with the skid buffer (see Configuration for the single-entry case):
  - M empty, input beat: beat enters M.
  - M full, out-transfer, input beat: input replaces M. S stays empty.
  - M full, no out-transfer, input beat: input enters S.
  - M and S full, out-transfer: S moves to M, S empties. No input is accepted because `in_ready`=0.
  - M full, out-transfer, no input beat: M empties.
- `occupancy` equals the count of valid M and S entries after the edge.

## Timing
- Reset values: `out_valid`=0, `out_data`=`NOP_VALUE`, `in_ready`=1, `occupancy`=0.
- Latency: 1 cycle from in-transfer to `out_valid` when the stage was empty.
- Throughput: 1 beat/cycle sustained while `out_ready`=1.
- With the skid buffer:
  - `in_ready` is a pure register output, `in_ready` = !S_valid.
  - There is no combinational path from `out_ready` to `in_ready`.
  - Deassertion of `out_ready` loses no beat: the beat in flight lands in S.
  - `in_ready` falls in the cycle after S fills. It rises in the cycle after S drains or after a flush.
- `in_ready` does not depend on `in_valid` in either configuration.
- Reset asserted mid-transfer or mid-stall discards everything at that edge. The first handshake is possible in the cycle after `rst_n` returns high.

## Configuration
- Macro: `PIPE_STAGE_BUF_SKID_EN`.
- Defined: two-entry skid buffer as described above. `occupancy` ranges 0–2. Timing is fully registered between upstream and downstream ready.
- Undefined:
  - Single entry M only, and S does not exist.
  - `in_ready` = !M_valid || `out_ready` (combinational).
  - `occupancy` is 0 or 1.
  - All other rules are unchanged: flush, NOP output, hold-on-stall, reset values.

## Test plan
- Reset then stream: hold `rst_n`=0 for 2 cycles, then send beats 0x1, 0x2, 0x3 on consecutive cycles with `out_ready`=1. Required: `out_data` shows 0x1, 0x2, 0x3 one cycle later each, no gaps, `occupancy`=1.
- Stall into skid (macro on):
  - Setup: M holds 0xA. Drop `out_ready` as 0xB arrives.
  - Required on the next cycle: `occupancy`=2, `in_ready`=0, `out_data`=0xA held.
  - Then raise `out_ready`. Required: 0xA then 0xB are delivered and `in_ready` returns to 1.
- Flush with full buffer: M=0xA, S=0xB, `flush`=1 with `in_valid`=1 and data 0xC. Required next cycle: `out_valid`=0, `out_data`=`NOP_VALUE`, `occupancy`=0, 0xC never appears.
- Simultaneous drain and fill (macro off): M=0x5, `out_ready`=1, `in_valid`=1 with data 0x6, `in_ready`=1 in the same cycle. Required: 0x6 in M next cycle, `occupancy`=1.
- Reset mid-stall: M=0x7 stalled, `rst_n`=0 for one edge. Required: all outputs at reset values. A beat 0x8 sent after release appears alone.
- Random-backpressure scoreboard: 10k beats with random `in_valid`/`out_ready` in both macro settings. Required: in-order, lossless and duplicate-free delivery, and `out_data` stable during every stall.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: generic pipeline stage register with valid/ready handshake,
// synchronous flush and an optional two-entry skid buffer.
// Latency: 1 cycle from in-transfer to out_valid when the stage was empty.
// Backpressure: out_ready=0 stalls the stage; with PIPE_STAGE_BUF_SKID_EN
// defined, in_ready is registered (!S_valid), otherwise in_ready = !M_valid || out_ready.
//
// Configuration macro: PIPE_STAGE_BUF_SKID_EN (defined = two-entry skid buffer,
// undefined = single main entry only).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   flush      invalidate every held entry at this edge; beats handshaken now are dropped
//   in_valid   upstream beat present
//   in_ready   stage can accept a beat
//   in_data    upstream payload (WIDTH bits)
//   out_valid  downstream beat present (main entry valid)
//   out_ready  downstream accepts; drive 0 to stall
//   out_data   downstream payload, NOP_VALUE whenever out_valid=0
//   occupancy  number of held entries (0..2)

module pipe_stage_buf #(
  parameter int unsigned      WIDTH     = 96,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // Main entry: always the oldest beat, drives the output side.
  logic             m_vld;
  logic [WIDTH-1:0] m_dat;

  logic xfer_in;
  logic xfer_out;

  assign xfer_in   = in_valid & in_ready;
  assign xfer_out  = m_vld & out_ready;

  assign out_valid = m_vld;
  // The NOP substitution happens at the output so the payload registers
  // never need a reset or a clear on flush.
  assign out_data  = m_vld ? m_dat : NOP_VALUE;

`ifdef PIPE_STAGE_BUF_SKID_EN

  // Skid entry: only ever holds the beat younger than M.
  logic             s_vld;
  logic [WIDTH-1:0] s_dat;

  // Next-state controls for the entries.
  logic m_vld_nxt;
  logic s_vld_nxt;
  logic m_load_in;   // M captures in_data
  logic m_load_s;    // M captures the skid entry
  logic s_load_in;   // S captures in_data

  // Registered ready: the skid entry absorbs the beat that may already be in
  // flight when out_ready drops, so upstream only needs to see S's state.
  assign in_ready  = ~s_vld;
  assign occupancy = 2'(m_vld) + 2'(s_vld);

  always_comb begin
    m_vld_nxt = m_vld;
    s_vld_nxt = s_vld;
    m_load_in = 1'b0;
    m_load_s  = 1'b0;
    s_load_in = 1'b0;

    if (s_vld) begin
      // Both full: in_ready is low, so only draining is possible.
      if (xfer_out) begin
        m_load_s  = 1'b1;
        s_vld_nxt = 1'b0;
      end
    end else if (!m_vld) begin
      if (xfer_in) begin
        m_load_in = 1'b1;
        m_vld_nxt = 1'b1;
      end
    end else if (xfer_out) begin
      // M leaves this cycle; a simultaneous input takes its place directly.
      if (xfer_in) begin
        m_load_in = 1'b1;
      end else begin
        m_vld_nxt = 1'b0;
      end
    end else if (xfer_in) begin
      // M is stalled: park the new beat behind it.
      s_load_in = 1'b1;
      s_vld_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
    end else begin
      m_vld <= m_vld_nxt;
      s_vld <= s_vld_nxt;
    end
  end

  // Payload registers carry no reset; their contents are ignored while the
  // matching valid bit is low.
  always_ff @(posedge clk) begin
    if (m_load_s) begin
      m_dat <= s_dat;
    end else if (m_load_in) begin
      m_dat <= in_data;
    end
    if (s_load_in) begin
      s_dat <= in_data;
    end
  end

`else

  logic m_vld_nxt;
  logic m_load_in;

  // Without a skid entry the stage can accept whenever M is empty or is
  // being emptied this cycle, which puts out_ready on the in_ready path.
  assign in_ready  = ~m_vld | out_ready;
  assign occupancy = 2'(m_vld);

  always_comb begin
    m_vld_nxt = m_vld;
    m_load_in = 1'b0;
    if (xfer_in) begin
      m_load_in = 1'b1;
      m_vld_nxt = 1'b1;
    end else if (xfer_out) begin
      m_vld_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      m_vld <= 1'b0;
    end else begin
      m_vld <= m_vld_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (m_load_in) begin
      m_dat <= in_data;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Testbench for pipe_stage_buf: directed scenarios followed by random
// valid/ready/flush/reset traffic, checked every cycle against a queue model.
// Works with PIPE_STAGE_BUF_SKID_EN either defined or undefined.

module tb_pipe_stage_buf;

  localparam int W = 96;
  localparam logic [W-1:0] NOP = 96'h0000_0000_0000_0000_0000_0013;

`ifdef PIPE_STAGE_BUF_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  always #5 clk = ~clk;

  pipe_stage_buf #(
    .WIDTH     (W),
    .NOP_VALUE (NOP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  // Reference model: the beats the stage currently holds, oldest first.
  logic [W-1:0] held[$];

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;
  bit chk_en = 1'b0;
  bit last_acc = 1'b0;

  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_dat = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares the DUT against the model, then advances the model to
  // what the coming edge must produce.
  always @(negedge clk) begin
    logic         exp_ir;
    logic [W-1:0] exp_dat;
    bit           has_beat;
    if (chk_en) begin
      has_beat = (held.size() != 0);
      if (SKID) exp_ir = (held.size() < 2);
      else      exp_ir = !has_beat || out_ready;
      exp_dat = has_beat ? held[0] : NOP;

      check("out_valid", W'(out_valid), W'(has_beat));
      check("out_data", out_data, exp_dat);
      check("occupancy", W'(occupancy), W'(held.size()));
      check("in_ready", W'(in_ready), W'(exp_ir));
      if (prev_stall) begin
        check("stall_hold_valid", W'(out_valid), W'(1));
        check("stall_hold_data", out_data, prev_dat);
      end

      last_acc   = in_valid && in_ready;
      prev_stall = rst_n && !flush && has_beat && !out_ready;
      prev_dat   = exp_dat;

      if (has_beat && out_ready) void'(held.pop_front());
      if (in_valid && exp_ir) begin
        held.push_back(in_data);
        n_acc++;
      end
      if (flush || !rst_n) held.delete();
    end
  end

  task automatic cyc(input bit v, input logic [W-1:0] d, input bit ordy,
                     input bit fl = 1'b0, input bit rn = 1'b1);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    rst_n     = rn;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_word();
    return {$urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [W-1:0] cur;
    bit           have;
    bit           keep;

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Reset for a second cycle, then stream three beats back to back.
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, W'(1), 1'b1);
    cyc(1'b1, W'(2), 1'b1);
    cyc(1'b1, W'(3), 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);

    // Stall into skid: 0xA lands in M, out_ready drops as 0xB arrives.
    cyc(1'b1, W'('hA), 1'b0);
    cyc(1'b1, W'('hB), 1'b0);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);

    // Flush while full, with a new beat 0xC offered in the flush cycle.
    cyc(1'b1, W'('hA), 1'b0);
    cyc(1'b1, W'('hB), 1'b0);
    cyc(1'b1, W'('hC), 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);

    // Simultaneous drain and fill.
    cyc(1'b1, W'('h5), 1'b0);
    cyc(1'b1, W'('h6), 1'b1);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1);

    // Reset while stalled, then a single beat after release.
    cyc(1'b1, W'('h7), 1'b0);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, W'('h8), 1'b0);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);

    // Random traffic; an offered beat is held until it is taken.
    n_acc = 0;
    have  = 1'b0;
    cur   = '0;
    for (int c = 0; c < 60000 && n_acc < 10000; c++) begin
      keep = have && !last_acc;
      if (!keep) begin
        have = ($urandom_range(0, 99) < 70);
        cur  = rnd_word();
      end
      cyc(have, cur, ($urandom_range(0, 99) < 60),
          ($urandom_range(0, 99) == 0), ($urandom_range(0, 499) != 0));
    end
    check("beat_budget", W'(n_acc >= 10000), W'(1));

    // Drain whatever is left.
    for (int c = 0; c < 6; c++) cyc(1'b0, '0, 1'b1);
    check("drained", W'(held.size()), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
